// File: rtl/genetic_eval_ctrl.sv
// Fitness-evaluation sequencer for the evolvable LUT grid: serial chromosome load, atomic commit,
// then a settle/sample sweep over all input vectors, counting matching output bits.
module genetic_eval_ctrl #(
   parameter int IN      = 3,
   parameter int OUT     = 1,
   parameter int CHROM_W = 1024,
   parameter int SETTLE  = 2,
   parameter int FIT_W   = $clog2(OUT*2**IN+1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  ser_valid,
   input  logic                  ser_data,
   output logic                  ser_ready,
   input  logic [OUT*2**IN-1:0]  target,
   output logic [CHROM_W-1:0]    cromossomo,
   output logic [IN-1:0]         inp,
   input  logic [OUT-1:0]        circ_out,
   output logic                  busy,
   output logic                  done,
   output logic [FIT_W-1:0]      fitness,
   output logic                  perfect
);

   localparam int NVEC = 2**IN;
   localparam int BC_W = (CHROM_W > 1) ? $clog2(CHROM_W) : 1;
   localparam int WC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(CHROM_W-1);
   localparam logic [WC_W-1:0]  WC_LAST  = WC_W'((SETTLE > 0) ? SETTLE-1 : 0);
   localparam logic [IN-1:0]    INP_LAST = IN'(NVEC-1);
   localparam logic [FIT_W-1:0] FIT_MAX  = FIT_W'(OUT*NVEC);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [BC_W-1:0]    bitcnt, bitcnt_nxt;
   logic [CHROM_W-1:0] shadow, shadow_nxt, crom_nxt;
   logic [WC_W-1:0]    wcnt, wcnt_nxt;
   logic [IN-1:0]      inp_nxt;
   logic [FIT_W-1:0]   acc, acc_nxt, fitness_nxt;
   logic               perfect_nxt;
   logic [OUT-1:0]     tgt_slice, match;
   logic [FIT_W-1:0]   match_cnt;

   always_comb begin
      tgt_slice = target[inp*OUT +: OUT];
      match     = ~(circ_out ^ tgt_slice);
      match_cnt = '0;
      for (int i = 0; i < OUT; i++) begin
         match_cnt = match_cnt + FIT_W'(match[i]);
      end
   end

   always_comb begin
      state_nxt   = state;
      bitcnt_nxt  = bitcnt;
      shadow_nxt  = shadow;
      crom_nxt    = cromossomo;
      wcnt_nxt    = wcnt;
      inp_nxt     = inp;
      acc_nxt     = acc;
      fitness_nxt = fitness;
      perfect_nxt = perfect;
      ser_ready   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt  = S_LOAD;
               bitcnt_nxt = '0;
               shadow_nxt = '0;
               acc_nxt    = '0;
            end
         end
         S_LOAD: begin
            ser_ready = 1'b1;
            busy      = 1'b1;
            if (ser_valid) begin
               shadow_nxt[bitcnt] = ser_data;
               bitcnt_nxt         = bitcnt + 1'b1;
               // commit includes the bit arriving on this very transfer
               if (bitcnt == BC_LAST) begin
                  crom_nxt = shadow_nxt;
                  inp_nxt  = '0;
                  wcnt_nxt = '0;
                  if (SETTLE == 0) state_nxt = S_SAMPLE;
                  else             state_nxt = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            busy = 1'b1;
            if (wcnt == WC_LAST) state_nxt = S_SAMPLE;
            else                 wcnt_nxt  = wcnt + 1'b1;
         end
         S_SAMPLE: begin
            busy    = 1'b1;
            acc_nxt = acc + match_cnt;
            if (inp == INP_LAST) begin
               // publish on entry to DONE so fitness is valid while done is high
               state_nxt   = S_DONE;
               fitness_nxt = acc_nxt;
               perfect_nxt = (acc_nxt == FIT_MAX);
            end else begin
               inp_nxt  = inp + 1'b1;
               wcnt_nxt = '0;
               if (SETTLE == 0) state_nxt = S_SAMPLE;
               else             state_nxt = S_SETTLE;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            inp_nxt   = '0;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         bitcnt     <= '0;
         shadow     <= '0;
         cromossomo <= '0;
         wcnt       <= '0;
         inp        <= '0;
         acc        <= '0;
         fitness    <= '0;
         perfect    <= 1'b0;
      end else begin
         state      <= state_nxt;
         bitcnt     <= bitcnt_nxt;
         shadow     <= shadow_nxt;
         cromossomo <= crom_nxt;
         wcnt       <= wcnt_nxt;
         inp        <= inp_nxt;
         acc        <= acc_nxt;
         fitness    <= fitness_nxt;
         perfect    <= perfect_nxt;
      end
   end

endmodule

// File: tb/tb_genetic_eval_ctrl.sv
// Directed bench for genetic_eval_ctrl: table of full evaluations on a 1024-bit instance,
// plus short-chromosome instances with a 1-cycle-lagged circuit for settle timing.
module tb_genetic_eval_ctrl;
   localparam int CW  = 1024;
   localparam int SCW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, s_start, ser_valid, ser_data, circ_mode;
   logic [7:0] target;

   logic          ser_ready, busy, done, perfect;
   logic [CW-1:0] crom;
   logic [2:0]    inp;
   logic [3:0]    fitness;
   logic [0:0]    circ_out;

   logic           a_ready, a_busy, a_done, a_perf, b_ready, b_busy, b_done, b_perf;
   logic [SCW-1:0] a_crom, b_crom;
   logic [2:0]     a_inp, b_inp;
   logic [3:0]     a_fit, b_fit;
   logic [0:0]     a_lag = 1'b0, b_lag = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   function automatic logic maj(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   assign circ_out = circ_mode ? 1'b0 : maj(inp);
   always @(posedge clk) begin
      a_lag <= maj(a_inp);
      b_lag <= maj(b_inp);
   end

   genetic_eval_ctrl #(.IN(3), .OUT(1), .CHROM_W(CW), .SETTLE(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ser_valid(ser_valid), .ser_data(ser_data),
      .ser_ready(ser_ready), .target(target), .cromossomo(crom), .inp(inp), .circ_out(circ_out),
      .busy(busy), .done(done), .fitness(fitness), .perfect(perfect));

   genetic_eval_ctrl #(.IN(3), .OUT(1), .CHROM_W(SCW), .SETTLE(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .ser_valid(ser_valid), .ser_data(ser_data),
      .ser_ready(a_ready), .target(target), .cromossomo(a_crom), .inp(a_inp), .circ_out(a_lag),
      .busy(a_busy), .done(a_done), .fitness(a_fit), .perfect(a_perf));

   // SETTLE=0 is outside the legal range; used only to show the lagged circuit is caught
   genetic_eval_ctrl #(.IN(3), .OUT(1), .CHROM_W(SCW), .SETTLE(0)) u_s0 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .ser_valid(ser_valid), .ser_data(ser_data),
      .ser_ready(b_ready), .target(target), .cromossomo(b_crom), .inp(b_inp), .circ_out(b_lag),
      .busy(b_busy), .done(b_done), .fitness(b_fit), .perfect(b_perf));

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] mkpat(input int seed);
      logic [CW-1:0] p;
      logic [31:0]   x;
      x = 32'(seed) * 32'h9E37_79B9 + 32'd1;
      for (int i = 0; i < CW; i++) begin
         x ^= x << 13;
         x ^= x >> 17;
         x ^= x << 5;
         p[i] = x[0];
      end
      return p;
   endfunction

   task automatic do_abort(input string nm);
      rst_n = 1'b0;
      #1;
      chk({nm, "_crom"}, crom, '0);
      chk({nm, "_inp"}, {1021'd0, inp}, '0);
      chk({nm, "_fitness"}, {1020'd0, fitness}, '0);
      chk({nm, "_perfect"}, perfect, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_ser_ready"}, ser_ready, 0);
      ser_valid = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_idle_busy"}, busy, 0);
      chk({nm, "_idle_ready"}, ser_ready, 0);
      ser_valid = 1'b0;
   endtask

   typedef struct {
      int seed; bit gaps; bit zero_circ; bit inject; int abort; int exp_fit; bit exp_perf;
   } vec_t;
   vec_t tbl[7];

   task automatic run_vec(input vec_t t, input int k);
      logic [CW-1:0] pat, old;
      logic [3:0]    fit_done;
      bit   [3:0]    gapseq;
      bit            stable_ok, order_ok, rdy, v, injected;
      int            idx, n, j, extra;
      pat = mkpat(t.seed);
      old = crom;
      circ_mode = t.zero_circ;
      gapseq = 4'b1001;
      injected = 0;
      start = 1'b1; ser_valid = 1'b1; ser_data = pat[0];
      @(posedge clk); #1;
      start = 1'b0;
      n = 0; idx = 0; stable_ok = 1;
      while (idx < CW && n < 6000) begin
         if (t.abort == 1 && idx == 500) begin
            do_abort($sformatf("v%0d_abort_load", k));
            return;
         end
         v = t.gaps ? gapseq[n % 4] : 1'b1;
         if (t.inject && idx == 10 && !injected) begin
            start = 1'b1; injected = 1;
         end
         ser_valid = v; ser_data = pat[idx];
         rdy = ser_ready;
         if (crom !== old) stable_ok = 0;
         @(posedge clk); #1;
         start = 1'b0;
         if (v && rdy) idx++;
         n++;
      end
      ser_valid = 1'b0;
      chk($sformatf("v%0d_load_count", k), idx, CW);
      chk($sformatf("v%0d_crom_stable", k), stable_ok, 1);
      chk($sformatf("v%0d_crom_commit", k), crom, pat);
      j = 0; order_ok = 1;
      while (!done && j < 100) begin
         if (j < 24 && inp !== 3'(j / 3)) order_ok = 0;
         if (t.abort == 2 && inp == 3'd5) begin
            do_abort($sformatf("v%0d_abort_eval", k));
            return;
         end
         if (t.inject && j == 1) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         j++; n++;
      end
      chk($sformatf("v%0d_done_seen", k), done, 1);
      chk($sformatf("v%0d_fitness", k), {1020'd0, fitness}, CW'(t.exp_fit));
      chk($sformatf("v%0d_perfect", k), perfect, CW'(t.exp_perf));
      chk($sformatf("v%0d_inp_order", k), order_ok, 1);
      if (!t.gaps) chk($sformatf("v%0d_latency", k), n + 1, CW + 1 + 24);
      fit_done = fitness;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("v%0d_start_in_done", k), busy, 0);
      extra = 0;
      for (int c = 0; c < 30; c++) begin
         if (done) extra++;
         @(posedge clk); #1;
      end
      chk($sformatf("v%0d_single_done", k), extra, 0);
      chk($sformatf("v%0d_fitness_held", k), {1020'd0, fitness}, {1020'd0, fit_done});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CW-1:0]  tmp, crom_before;
      logic [SCW-1:0] sp;
      logic [3:0]     af, bf;
      bit             ap, bp, aseen, bseen;
      int             n, acyc, bcyc;

      //            seed gaps zero inject abort fit perf
      tbl[0] = '{1, 0, 0, 0, 0, 8, 1};
      tbl[1] = '{2, 0, 1, 0, 0, 4, 0};
      tbl[2] = '{1, 1, 0, 0, 0, 8, 1};
      tbl[3] = '{3, 0, 0, 0, 1, 0, 0};
      tbl[4] = '{3, 0, 0, 0, 2, 0, 0};
      tbl[5] = '{4, 0, 0, 0, 0, 8, 1};
      tbl[6] = '{4, 0, 0, 1, 0, 8, 1};

      rst_n = 1'b0; start = 1'b0; s_start = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
      circ_mode = 1'b0; target = 8'b1110_1000;
      #3;
      chk("rst_crom", crom, '0);
      chk("rst_inp", {1021'd0, inp}, '0);
      chk("rst_fitness", {1020'd0, fitness}, '0);
      chk("rst_perfect", perfect, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ser_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ser_valid = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready_ignores_valid", ser_ready, 0);
      chk("idle_not_busy", busy, 0);
      ser_valid = 1'b0;

      for (int k = 0; k < 7; k++) run_vec(tbl[k], k);

      // settle timing on short chromosomes with a one-cycle-late circuit
      tmp = mkpat(9);
      sp = tmp[SCW-1:0];
      crom_before = crom;
      s_start = 1'b1; ser_valid = 1'b1; ser_data = sp[0];
      @(posedge clk); #1;
      s_start = 1'b0;
      chk("s_ready_in_load", {a_ready, b_ready}, 2'b11);
      n = 0;
      for (int i = 0; i < SCW; i++) begin
         ser_valid = 1'b1; ser_data = sp[i];
         @(posedge clk); #1;
         n++;
      end
      ser_valid = 1'b0;
      chk("s1_crom", a_crom, sp);
      chk("s0_crom", b_crom, sp);
      aseen = 0; bseen = 0; af = '0; bf = '0; ap = 0; bp = 0; acyc = 0; bcyc = 0;
      for (int c = 0; c < 60; c++) begin
         if (a_done && !aseen) begin aseen = 1; af = a_fit; ap = a_perf; acyc = n + 1; end
         if (b_done && !bseen) begin bseen = 1; bf = b_fit; bp = b_perf; bcyc = n + 1; end
         @(posedge clk); #1;
         n++;
      end
      chk("s1_done_seen", aseen, 1);
      chk("s1_fitness", af, 8);
      chk("s1_perfect", ap, 1);
      chk("s1_latency", acyc, SCW + 1 + 16);
      chk("s0_done_seen", bseen, 1);
      chk("s0_lag_fitness", bf, 5);
      chk("s0_lag_perfect", bp, 0);
      chk("s0_latency", bcyc, SCW + 1 + 8);
      chk("main_unaffected_busy", busy, 0);
      chk("main_unaffected_crom", crom, crom_before);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
